ir_nec_tx: RTL and testbench

Parametrised NEC infrared transmitter for the UART-to-IR path. It replaces the fixed enable/conduct IR sender and the free-running carrier generator. Command bytes arrive on a valid/ready handshake into a small FIFO. Each byte is sent as a complete NEC frame; the mark envelope is gated by an internally generated carrier with configurable frequency and duty cycle.

---
 rtl/ir_nec_tx_pkg.sv | 26 ++
 rtl/ir_nec_tx_if.sv | 9 +
 rtl/ir_nec_tx_carrier_gen.sv | 35 +++
 rtl/ir_nec_tx.sv | 190 +++++++++++++++++++
 tb/tb_ir_nec_tx.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ir_nec_tx_pkg.sv
// Shared NEC frame definitions: FSM state encoding and protocol unit counts.
// The REP_* states exist only when IR_REPEAT_EN is defined.
package ir_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
`ifdef IR_REPEAT_EN
    REP_MARK,
    REP_SPACE,
    REP_STOP,
`endif
    GAP
  } ir_state_e;

  localparam int LEAD_MARK_U  = 16;
  localparam int LEAD_SPACE_U = 8;
  localparam int REP_SPACE_U  = 4;
  localparam int ONE_SPACE_U  = 3;
  localparam int FRAME_U      = 192;

endpackage

// File: rtl/ir_nec_tx_if.sv
// Command byte valid/ready channel feeding the NEC transmitter FIFO.
interface ir_nec_tx_if;
  logic [7:0] CmdData;
  logic       CmdValid;
  logic       CmdReady;

  modport master (output CmdData, output CmdValid, input  CmdReady);
  modport slave  (input  CmdData, input  CmdValid, output CmdReady);
endinterface

// File: rtl/ir_nec_tx_carrier_gen.sv
// IR carrier generator. The carrier output is the value for the *next* cycle so
// the top can register IrSend alongside IrEnv; restart holds the phase at 0.
module ir_carrier_gen #(
  parameter int CLK_HZ     = 50000000,
  parameter int CARRIER_HZ = 38000,
  parameter int DUTY_PCT   = 33
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic restart,
  input  logic enable,
  output logic carrier
);

  localparam int CARR_DIV = CLK_HZ / CARRIER_HZ;
  localparam int CARR_HI  = CARR_DIV * DUTY_PCT / 100;
  localparam int CW       = (CARR_DIV > 1) ? $clog2(CARR_DIV) : 1;

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = '0;
    if (enable && !restart && (int'(cnt) != CARR_DIV - 1))
      cnt_nxt = cnt + CW'(1);
  end

  assign carrier = enable && (int'(cnt_nxt) < CARR_HI);

  always_ff @(posedge Clk) begin
    if (!Rst_n) cnt <= '0;
    else        cnt <= cnt_nxt;
  end

endmodule

// File: rtl/ir_nec_tx.sv
// NEC infrared transmitter: command FIFO, frame sequencer and carrier gating.
// Optional key-held repeat frames are enabled with the IR_REPEAT_EN macro.
module ir_nec_tx
  import ir_pkg::*;
#(
  parameter int          CLK_HZ     = 50000000,
  parameter int          CARRIER_HZ = 38000,
  parameter int          DUTY_PCT   = 33,
  parameter logic [15:0] ADDR       = 16'h00FF,
  parameter int          ADDR_MODE  = 0,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic       Clk,
  input  logic       Rst_n,
  ir_nec_tx_if.slave cmd,
  input  logic       Hold,
  output logic       Busy,
  output logic       IrEnv,
  output logic       IrSend
);

  localparam int T_UNIT = CLK_HZ * 9 / 16000;
  localparam int UW     = (T_UNIT > 1) ? $clog2(T_UNIT) : 1;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam logic [7:0] ADDR_LO = ADDR[7:0];
  localparam logic [7:0] ADDR_HI = (ADDR_MODE != 0) ? ADDR[15:8] : ~ADDR[7:0];

  ir_state_e     state;
  logic [UW-1:0] unit_cnt;
  logic [4:0]    seg_cnt;
  logic [7:0]    frame_u;
  logic [4:0]    bit_idx;
  logic [31:0]   shreg;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop, fifo_ne, gap_end, carrier;
  logic [7:0]    head;

  assign fifo_ne      = (count != '0);
  assign cmd.CmdReady = (count != (AW+1)'(FIFO_DEPTH));
  assign push         = cmd.CmdValid && cmd.CmdReady;
  assign gap_end      = (state == GAP) && (unit_cnt == '0) && (frame_u == 8'(FRAME_U - 1));
  assign pop          = fifo_ne && ((state == IDLE) || gap_end);
  assign head         = mem[rd_ptr];
  assign Busy         = (state != IDLE) || fifo_ne;

`ifndef IR_REPEAT_EN
  logic unused_hold;
  assign unused_hold = Hold;
`endif

  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr] <= cmd.CmdData;
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Carrier phase is held at zero through every space so each mark starts high.
  ir_carrier_gen #(
    .CLK_HZ     (CLK_HZ),
    .CARRIER_HZ (CARRIER_HZ),
    .DUTY_PCT   (DUTY_PCT)
  ) u_carrier (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .restart (!IrEnv),
    .enable  (Busy),
    .carrier (carrier)
  );

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state    <= IDLE;
      unit_cnt <= '0;
      seg_cnt  <= '0;
      frame_u  <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      IrEnv    <= 1'b0;
      IrSend   <= 1'b0;
    end else begin
      IrSend <= IrEnv && carrier;
      if (pop) begin
        state    <= LEAD_MARK;
        shreg    <= {~head, head, ADDR_HI, ADDR_LO};
        seg_cnt  <= 5'(LEAD_MARK_U - 1);
        unit_cnt <= UW'(T_UNIT - 1);
        frame_u  <= '0;
        bit_idx  <= '0;
        IrEnv    <= 1'b1;
        IrSend   <= carrier;
      end else if (state == IDLE) begin
        IrEnv <= 1'b0;
      end else if (unit_cnt != '0) begin
        unit_cnt <= unit_cnt - UW'(1);
      end else begin
        unit_cnt <= UW'(T_UNIT - 1);
        frame_u  <= frame_u + 8'd1;
        if (state == GAP) begin
          if (frame_u == 8'(FRAME_U - 1)) begin
            frame_u <= '0;
`ifdef IR_REPEAT_EN
            if (Hold) begin
              state   <= REP_MARK;
              seg_cnt <= 5'(LEAD_MARK_U - 1);
              IrEnv   <= 1'b1;
              IrSend  <= carrier;
            end else
`endif
              state <= IDLE;
          end
        end else if (seg_cnt != '0) begin
          seg_cnt <= seg_cnt - 5'd1;
        end else begin
          case (state)
            LEAD_MARK: begin
              state   <= LEAD_SPACE;
              seg_cnt <= 5'(LEAD_SPACE_U - 1);
              IrEnv   <= 1'b0;
              IrSend  <= 1'b0;
            end
            LEAD_SPACE: begin
              state  <= BIT_MARK;
              IrEnv  <= 1'b1;
              IrSend <= carrier;
            end
            BIT_MARK: begin
              state   <= BIT_SPACE;
              seg_cnt <= shreg[0] ? 5'(ONE_SPACE_U - 1) : 5'd0;
              IrEnv   <= 1'b0;
              IrSend  <= 1'b0;
            end
            BIT_SPACE: begin
              state  <= (bit_idx == 5'd31) ? STOP_MARK : BIT_MARK;
              shreg  <= shreg >> 1;
              bit_idx <= bit_idx + 5'd1;
              IrEnv  <= 1'b1;
              IrSend <= carrier;
            end
`ifdef IR_REPEAT_EN
            REP_MARK: begin
              state   <= REP_SPACE;
              seg_cnt <= 5'(REP_SPACE_U - 1);
              IrEnv   <= 1'b0;
              IrSend  <= 1'b0;
            end
            REP_SPACE: begin
              state  <= REP_STOP;
              IrEnv  <= 1'b1;
              IrSend <= carrier;
            end
            REP_STOP: begin
              state  <= GAP;
              IrEnv  <= 1'b0;
              IrSend <= 1'b0;
            end
`endif
            STOP_MARK: begin
              state  <= GAP;
              IrEnv  <= 1'b0;
              IrSend <= 1'b0;
            end
            default: begin
              state  <= IDLE;
              IrEnv  <= 1'b0;
              IrSend <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ir_nec_tx.sv
// Bench for ir_nec_tx: a negedge monitor decodes IrEnv/IrSend into frame records
// that are checked against expected words queued when bytes are pushed.
module tb_ir_nec_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hold = 1'b0;
  always #5 clk = ~clk;

  ir_nec_tx_if cmd_a ();
  ir_nec_tx_if cmd_b ();
  logic busy_a, env_a, send_a, busy_b, env_b, send_b;

  ir_nec_tx #(.CLK_HZ(16000), .CARRIER_HZ(4000), .DUTY_PCT(50), .ADDR(16'h00FF),
              .ADDR_MODE(0), .FIFO_DEPTH(4)) dut_a (
    .Clk(clk), .Rst_n(rst_n), .cmd(cmd_a), .Hold(hold),
    .Busy(busy_a), .IrEnv(env_a), .IrSend(send_a));

  ir_nec_tx #(.CLK_HZ(16000), .CARRIER_HZ(4000), .DUTY_PCT(50), .ADDR(16'h1234),
              .ADDR_MODE(1), .FIFO_DEPTH(4)) dut_b (
    .Clk(clk), .Rst_n(rst_n), .cmd(cmd_b), .Hold(1'b0),
    .Busy(busy_b), .IrEnv(env_b), .IrSend(send_b));

  typedef struct packed {
    logic [31:0] word;
    logic [15:0] lead_mark;
    logic [15:0] lead_space;
    logic [15:0] stop_mark;
    logic [7:0]  nbits;
    logic        is_rep;
    logic        shape_bad;
    logic [15:0] carr_err;
    logic [31:0] start;
  } frame_t;

  frame_t      obs_q[$];
  logic [31:0] exp_q[$];
  int total = 0;
  int bad = 0;

  int unsigned cyc = 0, mark_cycles = 0, idle_cyc = 0;
  logic mon_sel = 1'b0;
  logic in_frame = 1'b0, prev = 1'b0, b_prev = 1'b0;
  logic mon_e, mon_s, mon_b;
  int run_len = 0, run_idx = 0, pos = 0;
  frame_t cur;

  task automatic close_run(input int len);
    int k;
    if (run_idx == 0) cur.lead_mark = 16'(len);
    else if (run_idx == 1) begin
      cur.lead_space = 16'(len);
      cur.is_rep = (len < 50);
    end else if (cur.is_rep) begin
      if (run_idx == 2) cur.stop_mark = 16'(len);
      else cur.shape_bad = 1'b1;
    end else begin
      k = run_idx - 2;
      if (k < 64) begin
        if (k % 2 == 0) begin
          if (len != 9) cur.shape_bad = 1'b1;
        end else begin
          if (len == 27) cur.word[cur.nbits[4:0]] = 1'b1;
          else if (len != 9) cur.shape_bad = 1'b1;
          cur.nbits = cur.nbits + 8'd1;
        end
      end else if (k == 64) cur.stop_mark = 16'(len);
      else cur.shape_bad = 1'b1;
    end
    run_idx++;
  endtask

  always @(negedge clk) begin
    cyc++;
    mon_e = mon_sel ? env_b : env_a;
    mon_s = mon_sel ? send_b : send_a;
    mon_b = mon_sel ? busy_b : busy_a;
    if (b_prev && !mon_b) idle_cyc = cyc;
    b_prev = mon_b;
    if (mon_e) mark_cycles++;
    if (!rst_n) begin
      in_frame = 1'b0;
      prev = 1'b0;
      run_len = 0;
    end else begin
      if (mon_e && !in_frame) begin
        in_frame = 1'b1;
        cur = '0;
        cur.start = cyc;
        run_idx = 0;
        run_len = 0;
        prev = 1'b1;
      end
      if (in_frame) begin
        if (mon_e) begin
          if (!prev || run_len == 0) pos = 0;
          else pos++;
          if (mon_s !== ((pos % 4) < 2)) cur.carr_err++;
        end else if (mon_s !== 1'b0) cur.carr_err++;
        if (mon_e == prev) run_len++;
        else begin
          close_run(run_len);
          run_len = 1;
          prev = mon_e;
        end
        if (!mon_e && run_len >= 300) begin
          obs_q.push_back(cur);
          in_frame = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input bit sel, input logic [7:0] d);
    return sel ? {~d, d, 8'h12, 8'h34} : {~d, d, 8'h00, 8'hFF};
  endfunction

  task automatic push(input bit sel, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    if (sel) begin cmd_b.CmdData = d; cmd_b.CmdValid = 1'b1; end
    else begin cmd_a.CmdData = d; cmd_a.CmdValid = 1'b1; end
    while ((sel ? cmd_b.CmdReady : cmd_a.CmdReady) !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready", sel ? cmd_b.CmdReady : cmd_a.CmdReady, 1);
    @(posedge clk);
    exp_q.push_back(exp_word(sel, d));
    #1;
    cmd_a.CmdValid = 1'b0;
    cmd_b.CmdValid = 1'b0;
  endtask

  task automatic get_frame(output frame_t f);
    int n = 0;
    while (obs_q.size() == 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("frame_arrival", obs_q.size() != 0, 1);
    if (obs_q.size() != 0) f = obs_q.pop_front();
    else f = '0;
  endtask

  task automatic check_data(input string tag, input frame_t f);
    logic [31:0] w;
    w = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    chk({tag, "_word"}, f.word, w);
    chk({tag, "_lead_mark"}, f.lead_mark, 144);
    chk({tag, "_lead_space"}, f.lead_space, 72);
    chk({tag, "_nbits"}, f.nbits, 32);
    chk({tag, "_stop"}, f.stop_mark, 9);
    chk({tag, "_shape"}, f.shape_bad, 0);
    chk({tag, "_carrier"}, f.carr_err, 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while ((mon_sel ? busy_b : busy_a) && n < 4000);
    chk("idle_reached", mon_sel ? busy_b : busy_a, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    frame_t f;
    logic [31:0] prev_start;
    int unsigned m0;
    int n;
    cmd_a.CmdValid = 1'b0; cmd_a.CmdData = '0;
    cmd_b.CmdValid = 1'b0; cmd_b.CmdData = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_env", env_a, 0);
    chk("rst_send", send_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_ready", cmd_a.CmdReady, 1);

    // single frame, then idle exactly one frame period after leader start
    push(0, 8'h12);
    get_frame(f);
    check_data("single", f);
    wait_idle();
    chk("single_period", idle_cyc - f.start, 1728);

    // five pushes: one popped, four queued -> FIFO full
    push(0, 8'h01); push(0, 8'h80); push(0, 8'h3C); push(0, 8'hC3); push(0, 8'h7E);
    chk("full_ready", cmd_a.CmdReady, 0);
    for (int i = 0; i < 5; i++) begin
      get_frame(f);
      check_data($sformatf("b2b%0d", i), f);
      if (i > 0) chk($sformatf("b2b%0d_spacing", i), f.start - prev_start, 1728);
      prev_start = f.start;
    end
    wait_idle();

    // reset during bit 10 of 8'hA5
    push(0, 8'hA5);
    n = 0;
    do begin @(negedge clk); n++; end while (!env_a && n < 100);
    repeat (542) @(negedge clk);
    chk("mid_bit10_mark", env_a, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_env", env_a, 0);
    chk("midrst_send", send_a, 0);
    chk("midrst_busy", busy_a, 0);
    chk("midrst_ready", cmd_a.CmdReady, 1);
    @(negedge clk) rst_n = 1'b1;
    exp_q.delete();
    m0 = mark_cycles;
    repeat (2000) @(negedge clk);
    chk("midrst_no_marks", mark_cycles - m0, 0);
    chk("midrst_no_frames", obs_q.size(), 0);

    // extended address mode
    mon_sel = 1'b1;
    push(1, 8'h01);
    get_frame(f);
    check_data("ext", f);
    wait_idle();
    mon_sel = 1'b0;

`ifdef IR_REPEAT_EN
    hold = 1'b1;
    push(0, 8'h55);
    get_frame(f);
    check_data("rep_data", f);
    prev_start = f.start;
    for (int i = 0; i < 2; i++) begin
      get_frame(f);
      chk($sformatf("rep%0d_kind", i), f.is_rep, 1);
      chk($sformatf("rep%0d_mark", i), f.lead_mark, 144);
      chk($sformatf("rep%0d_space", i), f.lead_space, 36);
      chk($sformatf("rep%0d_stop", i), f.stop_mark, 9);
      chk($sformatf("rep%0d_shape", i), f.shape_bad, 0);
      chk($sformatf("rep%0d_carrier", i), f.carr_err, 0);
      chk($sformatf("rep%0d_spacing", i), f.start - prev_start, 1728);
      prev_start = f.start;
    end
    hold = 1'b0;
    wait_idle();
    chk("rep_end_period", idle_cyc - prev_start, 1728);
    repeat (500) @(negedge clk);
    chk("rep_no_more", obs_q.size(), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
